// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared FSM state type, checksum width and checksum-good predicate for prog_loader.
package prog_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} state_t;
  localparam int CKSUM_W = 8;
  function automatic logic cksum_ok(input logic [CKSUM_W-1:0] sum, input logic [CKSUM_W-1:0] b);
    logic [CKSUM_W-1:0] t;
    t = sum + b;
    return t == '0;
  endfunction
endpackage

// File: rtl/prog_ram.sv
// prog_ram: DEPTH x WORD_W simple dual-port RAM, synchronous write, registered read (read-before-write).
// Ports: clk, rst (async, clears read register only), i_we/i_wr_addr/i_wr_data write port,
//        i_rd_addr read address, o_rd_data registered read data.
module prog_ram #(
  parameter int WORD_W = 16,
  parameter int DEPTH = 128,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_rd_data <= '0;
    else o_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader into an internal instruction RAM, gating cpu_run until loaded.
// Ports: clk, rst (async active-high); ld_start/ld_len begin a load; ld_valid/ld_byte/ld_ready byte stream;
//        cpu_rd_addr/cpu_rd_data registered CPU fetch; cpu_run, load_err, words_loaded status.
// Macro PROG_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte that must bring the sum to zero.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int DEPTH = 128,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic [WORD_W-1:0] cpu_rd_data,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t DONE = CHECK;
`else
  localparam state_t DONE = RUN;
`endif
  state_t              r_state;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_words;
  logic [ADDR_W-1:0]   r_addr;
  logic [IDX_W-1:0]    r_idx;
  logic [CKSUM_W-1:0]  r_sum;
  logic [WORD_W-1:0]   r_buf;
  logic                r_err;
  logic                w_acc;
  logic                w_last;
  logic [WORD_W-1:0]   w_word;
  assign ld_ready = r_state == LOAD || r_state == CHECK;
  assign cpu_run = r_state == RUN;
  assign load_err = r_err;
  assign words_loaded = r_words;
  // ld_start wins over a byte presented on the same edge
  assign w_acc = ld_valid && ld_ready && !ld_start;
  assign w_last = w_acc && r_state == LOAD && r_idx == IDX_LAST;
  always_comb begin
    w_word = r_buf;
    w_word[{r_idx, 3'b000} +: 8] = ld_byte;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len <= '0;
      r_words <= '0;
      r_addr <= '0;
      r_idx <= '0;
      r_sum <= '0;
      r_buf <= '0;
      r_err <= 1'b0;
    end else if (ld_start) begin
      r_len <= ld_len;
      r_words <= '0;
      r_addr <= '0;
      r_idx <= '0;
      r_sum <= '0;
      r_err <= ld_len > LEN_MAX;
      r_state <= ld_len > LEN_MAX ? IDLE : ld_len == '0 ? DONE : LOAD;
    end else if (w_acc) begin
      case (r_state)
        LOAD: begin
          r_sum <= r_sum + ld_byte;
          r_buf <= w_word;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_addr <= r_addr + 1'b1;
            r_words <= r_words + 1'b1;
            if (r_words + 1'b1 == r_len) r_state <= DONE;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECK: begin
          r_state <= cksum_ok(r_sum, ld_byte) ? RUN : IDLE;
          r_err <= !cksum_ok(r_sum, ld_byte);
        end
`endif
        default: r_state <= r_state;
      endcase
    end
  end
  prog_ram #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_last),
    .i_wr_addr (r_addr),
    .i_wr_data (w_word),
    .i_rd_addr (cpu_rd_addr),
    .o_rd_data (cpu_rd_data)
  );
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader (WORD_W=16, DEPTH=8) against a byte-count model.
module tb_prog_loader;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start;
  logic [3:0]  ld_len;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic [2:0]  cpu_rd_addr;
  logic [15:0] cpu_rd_data;
  logic        cpu_run;
  logic        load_err;
  logic [3:0]  words_loaded;
  int errors = 0;
  int checks = 0;
  logic [15:0] m_mem [8];
  bit          m_known [8];
  int          m_len, m_cnt, m_words;
  bit          m_run, m_err, m_ready;
  logic [7:0]  m_sum, m_lo;
  always #5 clk = ~clk;
  prog_loader #(.WORD_W(16), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_start     (ld_start),
    .ld_len       (ld_len),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_ready     (ld_ready),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_outs(input string tag);
    chk({tag, ".run"}, 32'(cpu_run), 32'(m_run));
    chk({tag, ".ready"}, 32'(ld_ready), 32'(m_ready));
    chk({tag, ".err"}, 32'(load_err), 32'(m_err));
    chk({tag, ".words"}, 32'(words_loaded), 32'(m_words));
  endtask
  task automatic start(input int len);
    ld_start = 1'b1;
    ld_len = 4'(len);
    ld_valid = 1'($urandom);
    ld_byte = 8'($urandom);
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    m_len = len;
    m_cnt = 0;
    m_words = 0;
    m_sum = 8'h00;
    m_err = len > 8;
    m_run = len == 0 && !m_err && !CK;
    m_ready = !m_err && (len != 0 || CK);
    chk_outs("start");
  endtask
  task automatic send(input logic [7:0] b, input int maxgap);
    logic [15:0] old;
    bit wr, was_known;
    int a;
    repeat ($urandom_range(maxgap, 0)) tick;
    wr = m_ready && m_words < m_len && m_cnt % 2 == 1;
    a = m_words;
    if (wr) cpu_rd_addr = 3'(a);
    old = m_mem[a % 8];
    was_known = m_known[a % 8];
    ld_valid = 1'b1;
    ld_byte = b;
    tick;
    ld_valid = 1'b0;
    if (m_ready && m_words < m_len) begin
      m_sum = m_sum + b;
      if (m_cnt % 2 == 0) m_lo = b;
      else begin
        if (was_known) chk("rd_during_wr", 32'(cpu_rd_data), 32'(old));
        m_mem[a] = {b, m_lo};
        m_known[a] = 1'b1;
        m_words++;
        if (m_words == m_len) begin
          m_run = !CK;
          m_ready = CK;
        end
      end
      m_cnt++;
    end else if (m_ready) begin
      m_sum = m_sum + b;
      m_run = m_sum == 8'h00;
      m_err = !m_run;
      m_ready = 1'b0;
    end
    chk_outs("byte");
  endtask
  task automatic rd_all;
    for (int a = 0; a < 8; a++) begin
      if (m_known[a]) begin
        cpu_rd_addr = 3'(a);
        tick;
        chk("rd", 32'(cpu_rd_data), 32'(m_mem[a]));
      end
    end
  endtask
  task automatic basic(input int maxgap, input logic [7:0] ck);
    start(2);
    send(8'h34, maxgap);
    send(8'h12, maxgap);
    send(8'h78, maxgap);
    send(8'h56, maxgap);
    if (CK) send(ck, maxgap);
    rd_all;
  endtask
  initial begin
    rst = 1'b1;
    ld_start = 1'b0;
    ld_len = '0;
    ld_valid = 1'b0;
    ld_byte = '0;
    cpu_rd_addr = '0;
    for (int a = 0; a < 8; a++) m_known[a] = 1'b0;
    m_run = 0; m_err = 0; m_ready = 0; m_words = 0; m_len = 0; m_cnt = 0;
    tick;
    tick;
    chk_outs("reset");
    chk("reset.rd_data", 32'(cpu_rd_data), 32'h0);
    rst = 1'b0;
    tick;
    basic(0, 8'hEC);
    chk("basic.run", 32'(cpu_run), 32'h1);
    cpu_rd_addr = 3'd1;
    tick;
    chk("basic.rd1", 32'(cpu_rd_data), 32'h5678);
    if (CK) begin
      basic(0, 8'hED);
      chk("bad_ck.err", 32'(load_err), 32'h1);
    end
    start(9);
    chk("oversize.err", 32'(load_err), 32'h1);
    repeat (3) send(8'($urandom), 0);
    rd_all;
    basic(3, 8'hEC);
    chk("gaps.words", 32'(words_loaded), 32'h2);
    start(1);
    chk("reload.run", 32'(cpu_run), 32'h0);
    send(8'hAA, 1);
    send(8'hBB, 1);
    if (CK) send(8'h9B, 0);
    chk("reload.run_after", 32'(cpu_run), 32'h1);
    cpu_rd_addr = 3'd0;
    tick;
    chk("reload.rd0", 32'(cpu_rd_data), 32'hBBAA);
    rd_all;
    start(2);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    #2 rst = 1'b1;
    #1;
    m_run = 0; m_err = 0; m_ready = 0; m_words = 0;
    chk_outs("rst_mid");
    chk("rst_mid.rd_data", 32'(cpu_rd_data), 32'h0);
    tick;
    rst = 1'b0;
    tick;
    chk("rst_mid.rd_after", 32'(m_mem[0]), 32'h2211);
    rd_all;
    repeat (30) begin
      int len, nb;
      len = $urandom_range(9, 0);
      nb = ($urandom_range(3, 0) == 0) ? $urandom_range(2 * len, 0) : 2 * len;
      start(len);
      for (int i = 0; i < nb; i++) send(8'($urandom), 2);
      if (CK && nb == 2 * len && len <= 8) send(($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'(-m_sum), 1);
      rd_all;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised program-memory loader with an integrated word-wide instruction RAM, for the next generation of the core. It accepts a byte stream over a valid/ready handshake and assembles it little-endian into WORD_W-bit words. Words are written to consecutive addresses, and the CPU is held out of run until the programmed length has been loaded and, optionally, checksum-verified. The CPU fetches through a registered read port.

## Interface
- WORD_W, 16: instruction width in bits; must be a multiple of 8. Derived BYTES = WORD_W/8.
- DEPTH, 128: words of program RAM. Derived ADDR_W = $clog2(DEPTH).
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_start  in  1  pulse: begin a new load; samples ld_len.
- ld_len  in  ADDR_W+1  number of words in the program.
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  stream data byte.
- ld_ready  out  1  loader accepts a byte this cycle.
- cpu_rd_addr  in  ADDR_W  CPU fetch address.
- cpu_rd_data  out  WORD_W  registered fetch data.
- cpu_run  out  1  CPU may execute; low holds the CPU in reset.
- load_err  out  1  last load failed; sticky until next ld_start.
- words_loaded  out  ADDR_W+1  words written in current or last load.

## Operation
- FSM states:
  - IDLE: after reset or error.
  - LOAD: accepting data bytes.
  - CHECK: expecting the checksum byte; exists only with the macro.
  - RUN: cpu_run = 1.
- ld_start in any state:
  - Latches ld_len; clears byte index, write address, words_loaded, running sum and load_err.
  - ld_len > DEPTH: load_err = 1, goto IDLE.
  - ld_len == 0: goto RUN, or CHECK with the macro.
  - Otherwise: goto LOAD.
- ld_ready = 1 only in LOAD and CHECK. A byte is accepted when ld_valid && ld_ready.
- ld_start has priority over a simultaneous byte; that byte is dropped.
- Word assembly, little-endian: first byte goes to bits [7:0], byte i to [8i+7:8i].
- On acceptance of byte BYTES-1, the full word (stored bytes plus the incoming byte) is written to RAM[wr_addr] on that same edge. Then wr_addr++, words_loaded++, byte index resets to 0.
- When words_loaded reaches the latched length: goto RUN, or CHECK with the macro.
- Running sum is the 8-bit mod-256 sum of all accepted data bytes.
- RUN persists until the next ld_start or rst. ld_valid is ignored outside LOAD/CHECK.
- RAM contents are not reset. A partially loaded program keeps its written words.

## Timing
- Reset values:
  - State IDLE.
  - cpu_run = 0, ld_ready = 0, load_err = 0, words_loaded = 0.
  - cpu_rd_data = 0.
- ld_start sampled at edge k: new state and ld_ready are visible after edge k.
- cpu_run falls in the cycle after ld_start is sampled.
- Last data byte accepted at edge n (no macro): cpu_run = 1 after edge n.
- cpu_rd_data has a 1-cycle latency: address at edge t gives data after edge t.
- A write and a read to the same address on the same edge return the old data.
- rst mid-load aborts immediately: IDLE, partial word discarded, written words kept.
- No fixed throughput limit: one byte per cycle sustained. Gaps in ld_valid are allowed anywhere, including mid-word.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined:
  - After the final word, the FSM enters CHECK and accepts exactly one extra byte.
  - If (running sum + byte) mod 256 == 0: goto RUN.
  - Otherwise: load_err = 1, goto IDLE, cpu_run stays 0.
- Undefined:
  - No CHECK state; the final word goes straight to RUN.
  - load_err is raised only by an oversize ld_len.

## Structure
- Package prog_loader_pkg holds:
  - FSM state enum (IDLE, LOAD, CHECK, RUN).
  - CKSUM_W = 8.
  - The checksum-good predicate as a function.
- Sub-module prog_ram: simple dual-port RAM, DEPTH x WORD_W. One synchronous write port and one registered read port whose output resets to 0.
- The loader FSM, byte assembler and counters live in prog_loader.

## Test plan
All cases use WORD_W=16, DEPTH=8.
- Basic load, no macro: ld_len=2, bytes 34 12 78 56 back-to-back -> RAM[0]=0x1234, RAM[1]=0x5678, words_loaded=2. cpu_run=1 the cycle after the 4th byte; reading address 1 returns 0x5678 after one cycle.
- Checksum, macro on: same bytes then 0xEC -> RUN. Repeating with 0xED -> load_err=1, IDLE, cpu_run=0.
- Oversize: ld_len=9 -> load_err=1 the next cycle, ld_ready never asserted, RAM unchanged.
- Gaps/backpressure: same 4 bytes with ld_valid low 0-3 cycles between each byte, including mid-word -> identical RAM contents and words_loaded.
- Reload during RUN: ld_start -> cpu_run=0 next cycle. New ld_len=1, bytes AA BB -> RAM[0]=0xBBAA, RAM[1] keeps 0x5678.
- Reset mid-load: rst asserted after the 3rd byte -> all outputs 0, IDLE. RAM[0] holds the new word; RAM[1] is not written.
